maze_player_mover: RTL and testbench

- Downstream consumer of the per-cell wall-constraint arrays, i.e. the right-constraint array and its vertical counterpart (down-constraint array).
- Accepts one direction request at a time over a valid/ready handshake and checks the wall between the current and target cell.
- Updates the player position, then enforces a cooldown so held keys step at a controlled rate.
- Drives the position to the renderer and a goal flag to game control.

---
 rtl/maze_pkg.sv | 21 ++
 rtl/move_legal_check.sv | 33 +++
 rtl/maze_player_mover.sv | 138 +++++++++++++
 tb/tb_maze_player_mover.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared maze types and default dimensions for the player mover and later solver stages.
package maze_pkg;

  localparam int unsigned MAZE_SIZE_X = 40;
  localparam int unsigned MAZE_SIZE_Y = 20;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    COOLDOWN = 2'd2,
    WON      = 2'd3
  } mover_state_t;

endpackage

// File: rtl/move_legal_check.sv
// Combinational wall/edge test for one step from (pos_x, pos_y) in a given direction.
module move_legal_check
  import maze_pkg::*;
#(
  parameter int unsigned SIZE_X = MAZE_SIZE_X,
  parameter int unsigned SIZE_Y = MAZE_SIZE_Y,
  localparam int unsigned XW = $clog2(SIZE_X),
  localparam int unsigned YW = $clog2(SIZE_Y)
) (
  input  logic [XW-1:0]                   pos_x_i,
  input  logic [YW-1:0]                   pos_y_i,
  input  dir_t                            dir_i,
  input  logic [SIZE_Y-1:0][0:SIZE_X-1]   right_constraint_i,
  input  logic [SIZE_Y-1:0][0:SIZE_X-1]   down_constraint_i,
  output logic                            blocked_o
);

  // Edge guards wrap every array access so the +1 index is never out of range.
  always_comb begin
    blocked_o = 1'b1;
    case (dir_i)
      DIR_UP:    if (pos_y_i != '0)
                   blocked_o = down_constraint_i[pos_y_i][pos_x_i];
      DIR_DOWN:  if (pos_y_i != YW'(SIZE_Y - 1))
                   blocked_o = down_constraint_i[pos_y_i + YW'(1)][pos_x_i];
      DIR_LEFT:  if (pos_x_i != '0)
                   blocked_o = right_constraint_i[pos_y_i][pos_x_i];
      DIR_RIGHT: if (pos_x_i != XW'(SIZE_X - 1))
                   blocked_o = right_constraint_i[pos_y_i][pos_x_i + XW'(1)];
    endcase
  end

endmodule

// File: rtl/maze_player_mover.sv
// Player mover: accepts direction requests, checks walls, steps the position with a cooldown.
module maze_player_mover
  import maze_pkg::*;
#(
  parameter int unsigned size_y     = MAZE_SIZE_Y,
  parameter int unsigned size_x     = MAZE_SIZE_X,
  parameter int unsigned MOVE_DELAY = 4,
  parameter int unsigned START_X    = 0,
  parameter int unsigned START_Y    = 0,
  parameter int unsigned GOAL_X     = MAZE_SIZE_X - 1,
  parameter int unsigned GOAL_Y     = MAZE_SIZE_Y - 1
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          restart,
  input  logic [size_y-1:0][0:size_x-1] right_constraint,
  input  logic [size_y-1:0][0:size_x-1] down_constraint,
  input  logic [1:0]                    dir,
  input  logic                          dir_valid,
  output logic                          dir_ready,
  output logic [$clog2(size_x)-1:0]     pos_x,
  output logic [$clog2(size_y)-1:0]     pos_y,
  output logic                          move_done,
  output logic                          move_blocked,
  output logic                          at_goal,
  output logic [15:0]                   step_count
);

  localparam int unsigned XW = $clog2(size_x);
  localparam int unsigned YW = $clog2(size_y);
  localparam int unsigned CW = (MOVE_DELAY > 1) ? $clog2(MOVE_DELAY) : 1;

  mover_state_t  state_q, state_d;
  dir_t          dir_q, dir_d;
  logic [XW-1:0] pos_x_q, pos_x_d;
  logic [YW-1:0] pos_y_q, pos_y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   steps_q, steps_d;
  logic          done_q, done_d;
  logic          blk_q, blk_d;
  logic          rdy_en_q;
  logic          blocked;

  move_legal_check #(
    .SIZE_X (size_x),
    .SIZE_Y (size_y)
  ) u_check (
    .pos_x_i            (pos_x_q),
    .pos_y_i            (pos_y_q),
    .dir_i              (dir_q),
    .right_constraint_i (right_constraint),
    .down_constraint_i  (down_constraint),
    .blocked_o          (blocked)
  );

  assign at_goal      = (pos_x_q == XW'(GOAL_X)) && (pos_y_q == YW'(GOAL_Y));
  // rdy_en_q holds dir_ready low for the first cycle after reset release.
  assign dir_ready    = (state_q == IDLE) && rdy_en_q;
  assign pos_x        = pos_x_q;
  assign pos_y        = pos_y_q;
  assign move_done    = done_q;
  assign move_blocked = blk_q;
  assign step_count   = steps_q;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    cnt_d   = cnt_q;
    steps_d = steps_q;
    done_d  = 1'b0;
    blk_d   = 1'b0;
    if (restart) begin
      state_d = IDLE;
      pos_x_d = XW'(START_X);
      pos_y_d = YW'(START_Y);
      steps_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dir_valid && dir_ready) begin
            dir_d   = dir_t'(dir);
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (blocked) begin
            blk_d   = 1'b1;
            state_d = IDLE;
          end else begin
            case (dir_q)
              DIR_UP:    pos_y_d = pos_y_q - YW'(1);
              DIR_DOWN:  pos_y_d = pos_y_q + YW'(1);
              DIR_LEFT:  pos_x_d = pos_x_q - XW'(1);
              DIR_RIGHT: pos_x_d = pos_x_q + XW'(1);
            endcase
            if (steps_q != '1) steps_d = steps_q + 16'd1;
            done_d  = 1'b1;
            cnt_d   = CW'(MOVE_DELAY - 1);
            state_d = COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (cnt_q == '0) state_d = at_goal ? WON : IDLE;
          else             cnt_d   = cnt_q - CW'(1);
        end
        WON: state_d = WON;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      dir_q    <= DIR_UP;
      pos_x_q  <= XW'(START_X);
      pos_y_q  <= YW'(START_Y);
      cnt_q    <= '0;
      steps_q  <= '0;
      done_q   <= 1'b0;
      blk_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      cnt_q    <= cnt_d;
      steps_q  <= steps_d;
      done_q   <= done_d;
      blk_q    <= blk_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_maze_player_mover.sv
// Self-checking bench for maze_player_mover against a cell/wall level reference model.
module tb_maze_player_mover;

  localparam int SX = 40;
  localparam int SY = 20;
  localparam int MD = 4;
  localparam int GX = 39;
  localparam int GY = 19;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic restart = 1'b0;
  logic dir_valid = 1'b0;
  logic [1:0] dir = 2'd0;
  logic [SY-1:0][0:SX-1] rc;
  logic [SY-1:0][0:SX-1] dc;
  logic dir_ready, move_done, move_blocked, at_goal;
  logic [5:0] pos_x;
  logic [4:0] pos_y;
  logic [15:0] step_count;

  int total = 0;
  int bad = 0;
  int mx = 0, my = 0, msteps = 0;
  bit mwon = 1'b0;

  maze_player_mover #(
    .size_y     (SY),
    .size_x     (SX),
    .MOVE_DELAY (MD),
    .START_X    (0),
    .START_Y    (0),
    .GOAL_X     (GX),
    .GOAL_Y     (GY)
  ) dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .restart          (restart),
    .right_constraint (rc),
    .down_constraint  (dc),
    .dir              (dir),
    .dir_valid        (dir_valid),
    .dir_ready        (dir_ready),
    .pos_x            (pos_x),
    .pos_y            (pos_y),
    .move_done        (move_done),
    .move_blocked     (move_blocked),
    .at_goal          (at_goal),
    .step_count       (step_count)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A step is legal if the target cell is inside the grid and no wall separates the two cells.
  function automatic bit model_blocked(int x, int y, int d);
    int tx = x;
    int ty = y;
    case (d)
      0: ty = y - 1;
      1: ty = y + 1;
      2: tx = x - 1;
      default: tx = x + 1;
    endcase
    if (tx < 0 || tx >= SX || ty < 0 || ty >= SY) return 1'b1;
    if (tx != x) return rc[y][(tx > x) ? tx : x];
    return dc[(ty > y) ? ty : y][x];
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; msteps = 0; mwon = 1'b0;
  endtask

  task automatic check_pos(input string tag);
    check({tag, "_x"}, pos_x, mx);
    check({tag, "_y"}, pos_y, my);
    check({tag, "_steps"}, step_count, msteps);
    check({tag, "_goal"}, at_goal, (mx == GX && my == GY));
  endtask

  // Called and returning at a negedge; handshake happens at the following posedge.
  task automatic do_move(input int d, input bit skip_cool);
    int w = 0;
    bit blk;
    while (dir_ready !== 1'b1 && w < 40) begin
      @(negedge Clk);
      w++;
    end
    check("ready_before_req", dir_ready, 1);
    blk = model_blocked(mx, my, d);
    dir = 2'(d);
    dir_valid = 1'b1;
    @(negedge Clk);
    dir_valid = 1'b0;
    dir = 2'($urandom);
    check("check_cycle_ready", dir_ready, 0);
    check("check_cycle_pulse", {move_done, move_blocked}, 0);
    if (!blk) begin
      case (d)
        0: my--;
        1: my++;
        2: mx--;
        default: mx++;
      endcase
      if (msteps < 65535) msteps++;
    end
    @(negedge Clk);
    check("move_done", move_done, !blk);
    check("move_blocked", move_blocked, blk);
    check("ready_after_check", dir_ready, blk);
    check_pos("after_move");
    if (!blk && !skip_cool) begin
      for (int k = 0; k < MD - 1; k++) begin
        @(negedge Clk);
        check("cool_ready", dir_ready, 0);
        check("cool_pulse", {move_done, move_blocked}, 0);
      end
      @(negedge Clk);
      mwon = (mx == GX && my == GY);
      check("ready_after_cool", dir_ready, !mwon);
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge Clk);
    restart = 1'b0;
    model_reset();
    check_pos("restart");
    check("restart_pulse", {move_done, move_blocked}, 0);
    check("restart_ready", dir_ready, 1);
  endtask

  initial begin
    rc = '0;
    dc = '0;
    repeat (3) @(negedge Clk);
    check_pos("reset");
    check("reset_ready", dir_ready, 0);
    check("reset_pulse", {move_done, move_blocked}, 0);
    Reset_n = 1'b1;
    #1 check("release_ready", dir_ready, 0);
    @(negedge Clk);
    check("idle_ready", dir_ready, 1);

    // Open maze: edges block up/left at origin, right succeeds.
    do_move(0, 1'b0);
    do_move(2, 1'b0);
    do_move(3, 1'b0);

    // Restart coinciding with a handshake must drop the request.
    dir = 2'd3;
    dir_valid = 1'b1;
    restart = 1'b1;
    @(negedge Clk);
    dir_valid = 1'b0;
    restart = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      check("rst_hs_pulse", {move_done, move_blocked}, 0);
      check_pos("rst_hs");
      check("rst_hs_ready", dir_ready, 1);
      @(negedge Clk);
    end

    // Wall to the right of the origin, open path downward.
    rc[0][1] = 1'b1;
    do_move(3, 1'b0);
    do_move(1, 1'b0);
    rc[0][1] = 1'b0;

    // Asynchronous reset while cooling down.
    do_move(3, 1'b1);
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    check_pos("async_reset");
    check("async_reset_ready", dir_ready, 0);
    check("async_reset_pulse", {move_done, move_blocked}, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1 check("rerelease_ready", dir_ready, 0);
    @(negedge Clk);
    check("rerelease_idle_ready", dir_ready, 1);

    // Random walls and random requests.
    for (int y = 0; y < SY; y++)
      for (int x = 0; x < SX; x++) begin
        rc[y][x] = ($urandom_range(3) == 0);
        dc[y][x] = ($urandom_range(3) == 0);
      end
    for (int i = 0; i < 80 && !mwon; i++)
      do_move(int'($urandom_range(3)), 1'b0);
    rc = '0;
    dc = '0;
    do_restart();

    // Walk the open maze to the goal.
    for (int i = 0; i < GX; i++) do_move(3, 1'b0);
    for (int i = 0; i < GY; i++) do_move(1, 1'b0);
    check("won_flag", mwon, 1);
    dir = 2'd0;
    dir_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      check("won_ready", dir_ready, 0);
      check("won_pulse", {move_done, move_blocked}, 0);
      check_pos("won_frozen");
    end
    dir_valid = 1'b0;
    do_restart();
    do_move(1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
